// File: rtl/fsm_core.sv
// fsm_core: overlapping serial detector for pattern 10110 (first bit received is MSB).
// Define FSM_CORE_MEALY_EN to make y a combinational Mealy flag; default build is Moore.
module fsm_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic       y,
  output logic [3:0] ps1,
  output logic [3:0] ns1
);

  // state | meaning
  // S0    | idle, no partial match
  // S1    | seen "1"
  // S2    | seen "10"
  // S3    | seen "101"
  // S4    | seen "1011"
  // S5    | seen "10110", pattern detected
  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5
  } state_e;

  state_e state_q;
  state_e state_d;

  // Decoded from the ps1 port so an upset of the visible state code recovers like a real one.
  always_comb begin
    state_d = S0;
    if (!rst) begin
      case (ps1)
        S0:      state_d = x ? S1 : S0;
        S1:      state_d = x ? S1 : S2;
        S2:      state_d = x ? S3 : S0;
        S3:      state_d = x ? S4 : S2;
        S4:      state_d = x ? S1 : S5;
        S5:      state_d = x ? S3 : S0;
        default: state_d = S0;
      endcase
    end
  end

  assign ps1 = state_q;
  assign ns1 = state_d;

`ifdef FSM_CORE_MEALY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign y = (ps1 == S4) && !x && !rst;
`else
  logic y_q;

  // y_q tracks "next state is S5", so it is high exactly while ps1 == S5.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= (state_d == S5);
    end
  end

  assign y = y_q;
`endif

endmodule

// File: tb/tb_fsm_core.sv
// Self-checking bench for fsm_core; the reference model is a longest-suffix matcher
// against 10110, independent of the DUT transition table.
module tb_fsm_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x   = 1'b0;
  logic       y;
  logic [3:0] ps1;
  logic [3:0] ns1;

  fsm_core dut (
    .clk(clk),
    .rst(rst),
    .x  (x),
    .y  (y),
    .ps1(ps1),
    .ns1(ns1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ps;
    logic       y;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [4:0] PAT = 5'b10110;

  int         checks   = 0;
  int         failures = 0;
  logic [4:0] hist     = '0;
  int         nbits    = 0;
  int         cur      = 0;
  int         pulses   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Longest k such that the last k received bits equal the first k pattern bits.
  function automatic int match_len(input logic [4:0] h, input int n);
    for (int k = 5; k >= 1; k--) begin
      if (k <= n) begin
        bit ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (h[k-1-i] != PAT[4-i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    hist  = '0;
    nbits = 0;
    cur   = 0;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = 1'b1;
      x   = i[0];
      @(posedge clk);
      #1;
      check("rst_ps1", ps1, 0);
      check("rst_ns1", ns1, 0);
      check("rst_y", y, 0);
    end
    model_reset();
  endtask

  task automatic step(input logic xb);
    exp_t       e;
    logic [4:0] h;
    int         n;
    int         nxt;
    @(negedge clk);
    rst = 1'b0;
    x   = xb;
    h   = {hist[3:0], xb};
    n   = (nbits < 5) ? nbits + 1 : 5;
    nxt = match_len(h, n);
    #1;
    check("ns1", ns1, nxt);
`ifdef FSM_CORE_MEALY_EN
    check("y_mealy", y, (cur == 4 && !xb) ? 1 : 0);
    if (y === 1'b1) pulses++;
`endif
    e.ps = nxt[3:0];
    e.y  = (nxt == 5);
    sb_q.push_back(e);
    hist  = h;
    nbits = n;
    cur   = nxt;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("ps1", ps1, e.ps);
`ifndef FSM_CORE_MEALY_EN
    check("y_moore", y, e.y);
    if (y === 1'b1) pulses++;
`endif
  endtask

  task automatic run_seq(input string tag, input logic [7:0] bits, input int len, input int exp_pulses);
    logic [7:0] b;
    b      = bits;
    pulses = 0;
    for (int i = len - 1; i >= 0; i--) step(b[i]);
    check(tag, pulses, exp_pulses);
  endtask

  initial begin
    do_reset(5);

    run_seq("pulses_single", 8'b0001_0110, 5, 1);

    do_reset(1);
    run_seq("pulses_overlap", 8'b1011_0110, 8, 2);

    do_reset(1);
    run_seq("pulses_nonmatch", 8'b1110_0100, 8, 0);

    // Partial match 1011, then a one-cycle reset with x=0 must discard it.
    do_reset(1);
    run_seq("pulses_partial", 8'b0000_1011, 4, 0);
    @(negedge clk);
    rst = 1'b1;
    x   = 1'b0;
    #1;
    check("midrst_ns1", ns1, 0);
    check("midrst_y", y, 0);
    @(posedge clk);
    #1;
    check("midrst_ps1", ps1, 0);
    check("midrst_y_post", y, 0);
    model_reset();
    run_seq("pulses_after_rst", 8'b0001_0110, 5, 1);

    // Illegal code recovery.
    do_reset(1);
    @(negedge clk);
    rst = 1'b0;
    x   = 1'b1;
    force dut.ps1 = 4'd9;
    #1;
    check("ill_ns1", ns1, 0);
    check("ill_y", y, 0);
    @(posedge clk);
    #1;
    release dut.ps1;
    #1;
    check("ill_ps1", ps1, 0);
    check("ill_y_post", y, 0);
    model_reset();
    run_seq("pulses_after_ill", 8'b0001_0110, 5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_core.md
FSM_CORE -- requirements
Module: fsm_core

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge; one clock domain.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 x  input  1  serial data bit; sampled every rising clk edge.
REQ-004 y  output  1  detect flag for serial pattern 1-0-1-1-0.
REQ-005 ps1  output  4  present-state register, encoded state value.
REQ-006 ns1  output  4  combinational next-state value.

Function
REQ-007 Block SHALL be an overlapping detector for serial pattern 10110; first-received bit is MSB.
REQ-008 State encoding SHALL be: S0=4'd0 idle, S1=4'd1 "1", S2=4'd2 "10", S3=4'd3 "101", S4=4'd4 "1011", S5=4'd5 "10110".
REQ-009 Transitions SHALL be as follows (x=0 / x=1): S0->S0/S1; S1->S2/S1; S2->S0/S3; S3->S2/S4; S4->S5/S1; S5->S0/S3.
REQ-010 Codes 4'd6..4'd15 are illegal; next state from any illegal code SHALL be S0 for both x values; y SHALL be 0 in illegal states.
REQ-011 ps1 SHALL load ns1 on every rising clk edge when rst=0.
REQ-012 ns1 SHALL be a purely combinational function of ps1 and x; ns1 SHALL be S0 while rst=1.
REQ-013 Default (Moore) output: y SHALL be 1 exactly when ps1==S5, so assertion follows the edge that samples the final 0; latency is 1 cycle.
REQ-014 Overlap: after a detection, trailing "1" and "101" suffixes SHALL be reused per REQ-009, so 10110110 yields two detections.
REQ-015 y SHALL assert for one cycle per detection; consecutive detections SHALL NOT merge.
REQ-016 No output SHALL be X after the first reset edge.

Reset
REQ-017 On a rising clk edge with rst=1: ps1=S0 and y=0; ns1 reads S0 while rst is high.
REQ-018 Reset asserted mid-sequence SHALL discard partial match; detection restarts from S0 after rst falls.
REQ-019 Before the first reset edge, outputs are undefined; the bench SHALL apply reset first.

Configuration
REQ-020 Macro FSM_CORE_MEALY_EN: when defined, y SHALL be combinational: y = (ps1==S4 and x==0 and rst==0), asserting in the same cycle the final 0 is present, one cycle earlier than Moore; S5 is still entered for state tracking.
REQ-021 When FSM_CORE_MEALY_EN is undefined, y SHALL follow REQ-013 (Moore); ports, state encoding and transitions SHALL be identical in both builds.

Verification
REQ-022 Reset: rst=1 for 5 cycles with x toggling -> ps1=0, ns1=0, y=0 throughout.
REQ-023 Single detect: after reset, x=1,0,1,1,0 on successive edges -> ps1 sequence 1,2,3,4,5; y=1 for exactly the cycle ps1=5 (Moore); in Mealy build y=1 during the cycle x=0 with ps1=4.
REQ-024 Overlap: x=1,0,1,1,0,1,1,0 -> two one-cycle y pulses, at ps1=5 after bit 5 and after bit 8.
REQ-025 Non-match: x=1,1,1,0,0,1,0,0 -> y stays 0; ps1 follows REQ-009 (1,1,1,2,0,1,2,0).
REQ-026 Reset mid-sequence: x=1,0,1,1, then rst=1 for 1 cycle with x=0 -> ps1=0, no y pulse; then 1,0,1,1,0 -> one detection.
REQ-027 Illegal recovery: force ps1=4'd9 for one cycle, then release -> ns1=0, ps1=0 on the next edge, y=0.
